// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pulse-protocol memory port between two masters.
// m0 is the MMU downstream port, m1 a secondary master (loader / debug).
// Round-robin arbitration, one pending slot per master, a single memory
// transaction in flight, and an optional response timeout that aborts the
// transaction with a zero-data response plus a bus_error pulse.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TO_WIDTH       = 16
) (
    input  logic        clk,
    input  logic        rstn,

    // master 0 (MMU downstream)
    input  logic        m0_request_enable,
    input  logic        m0_req_mode,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    input  logic [3:0]  m0_req_wstrb,
    output logic        m0_response_enable,
    output logic [31:0] m0_resp_data,

    // master 1 (loader / debug)
    input  logic        m1_request_enable,
    input  logic        m1_req_mode,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic [3:0]  m1_req_wstrb,
    output logic        m1_response_enable,
    output logic [31:0] m1_resp_data,

    // memory side
    output logic        request_enable,
    output logic        req_mode,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        response_enable,
    input  logic [31:0] resp_data,

    // status
    output logic        busy,
    output logic        grant_id,
    output logic        bus_error
);

    // One request as carried by the pulse protocol.
    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RESP = 2'd1,
        S_RESPOND   = 2'd2
    } state_t;

    // FSM and registered outputs
    state_t              state_q;
    logic                last_grant_q;
    logic [TO_WIDTH-1:0] cnt_q;
    logic                req_en_q;
    req_t                req_q;
    logic                grant_id_q;
    logic                bus_error_q;
    logic                m0_rsp_en_q;
    logic [31:0]         m0_rsp_data_q;
    logic                m1_rsp_en_q;
    logic [31:0]         m1_rsp_data_q;

    // pending slots
    logic                pend0_q;
    req_t                pend0_req_q;
    logic                pend1_q;
    req_t                pend1_req_q;

    // combinational arbitration results
    req_t                live0;
    req_t                live1;
    logic                want0;
    logic                want1;
    logic                grant_go;
    logic                grant_sel;
    logic                grant0;
    logic                grant1;
    req_t                grant_req_d;
    logic [TO_WIDTH-1:0] cnt_d;
    logic                to_hit;

    assign live0 = '{mode: m0_req_mode, addr: m0_req_addr,
                     wdata: m0_req_wdata, wstrb: m0_req_wstrb};
    assign live1 = '{mode: m1_req_mode, addr: m1_req_addr,
                     wdata: m1_req_wdata, wstrb: m1_req_wstrb};

    // Demand per master, round-robin pick and selection of the request source.
    always_comb begin
        want0       = pend0_q | m0_request_enable;
        want1       = pend1_q | m1_request_enable;
        grant_go    = (state_q == S_IDLE) && (want0 || want1);
        // On a tie the master that did not win last time goes next;
        // otherwise whichever master wants service.
        grant_sel   = (want0 && want1) ? ~last_grant_q : want1;
        grant0      = grant_go && !grant_sel;
        grant1      = grant_go &&  grant_sel;
        grant_req_d = live0;
        if (grant_sel) begin
            grant_req_d = pend1_q ? pend1_req_q : live1;
        end else begin
            grant_req_d = pend0_q ? pend0_req_q : live0;
        end
    end

    // Timeout detection: abort on the WAIT_RESP cycle that brings the count to the limit.
    always_comb begin
        cnt_d  = cnt_q + TO_WIDTH'(1);
        to_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == TO_WIDTH'(TIMEOUT_CYCLES));
    end

    // Pending slots: hold a pulse that was not granted on its own edge; a pulse
    // arriving while the slot is already occupied is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend0_q     <= 1'b0;
            pend0_req_q <= '0;
            pend1_q     <= 1'b0;
            pend1_req_q <= '0;
        end else begin
            if (grant0) begin
                pend0_q <= 1'b0;
            end else if (m0_request_enable && !pend0_q) begin
                pend0_q     <= 1'b1;
                pend0_req_q <= live0;
            end

            if (grant1) begin
                pend1_q <= 1'b0;
            end else if (m1_request_enable && !pend1_q) begin
                pend1_q     <= 1'b1;
                pend1_req_q <= live1;
            end
        end
    end

    // Transaction FSM with all memory-side and response outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            req_en_q      <= 1'b0;
            req_q         <= '0;
            grant_id_q    <= 1'b0;
            bus_error_q   <= 1'b0;
            m0_rsp_en_q   <= 1'b0;
            m0_rsp_data_q <= '0;
            m1_rsp_en_q   <= 1'b0;
            m1_rsp_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_go) begin
                        req_en_q     <= 1'b1;
                        req_q        <= grant_req_d;
                        grant_id_q   <= grant_sel;
                        last_grant_q <= grant_sel;
                        cnt_q        <= '0;
                        state_q      <= S_WAIT_RESP;
                    end
                end

                S_WAIT_RESP: begin
                    // The memory request is a single-cycle pulse.
                    req_en_q <= 1'b0;
                    if (response_enable) begin
                        // A response on the timeout edge wins over the abort.
                        if (grant_id_q) begin
                            m1_rsp_en_q   <= 1'b1;
                            m1_rsp_data_q <= resp_data;
                        end else begin
                            m0_rsp_en_q   <= 1'b1;
                            m0_rsp_data_q <= resp_data;
                        end
                        state_q <= S_RESPOND;
                    end else if (to_hit) begin
                        if (grant_id_q) begin
                            m1_rsp_en_q   <= 1'b1;
                            m1_rsp_data_q <= '0;
                        end else begin
                            m0_rsp_en_q   <= 1'b1;
                            m0_rsp_data_q <= '0;
                        end
                        bus_error_q <= 1'b1;
                        state_q     <= S_RESPOND;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_d;
                    end
                end

                S_RESPOND: begin
                    m0_rsp_en_q <= 1'b0;
                    m1_rsp_en_q <= 1'b0;
                    bus_error_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign request_enable     = req_en_q;
    assign req_mode           = req_q.mode;
    assign req_addr           = req_q.addr;
    assign req_wdata          = req_q.wdata;
    assign req_wstrb          = req_q.wstrb;
    assign m0_response_enable = m0_rsp_en_q;
    assign m0_resp_data       = m0_rsp_data_q;
    assign m1_response_enable = m1_rsp_en_q;
    assign m1_resp_data       = m1_rsp_data_q;
    assign busy               = (state_q != S_IDLE);
    assign grant_id           = grant_id_q;
    assign bus_error          = bus_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected memory
// requests and master responses into queues, a memory model answers from a
// plan queue, and a monitor pops and compares whenever the DUT pulses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_request_enable, m0_req_mode;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic [3:0]  m0_req_wstrb;
    logic        m0_response_enable;
    logic [31:0] m0_resp_data;
    logic        m1_request_enable, m1_req_mode;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic [3:0]  m1_req_wstrb;
    logic        m1_response_enable;
    logic [31:0] m1_resp_data;
    logic        request_enable, req_mode;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        response_enable;
    logic [31:0] resp_data;
    logic        busy, grant_id, bus_error;

    mem_arbiter #(.TIMEOUT_CYCLES(8), .TO_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn),
        .m0_request_enable(m0_request_enable), .m0_req_mode(m0_req_mode),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
        .m0_response_enable(m0_response_enable), .m0_resp_data(m0_resp_data),
        .m1_request_enable(m1_request_enable), .m1_req_mode(m1_req_mode),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
        .m1_response_enable(m1_response_enable), .m1_resp_data(m1_resp_data),
        .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(response_enable), .resp_data(resp_data),
        .busy(busy), .grant_id(grant_id), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        gid;
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_exp_t;

    typedef struct {
        bit          respond;
        int          delay;
        logic [31:0] data;
    } plan_t;

    req_exp_t exp_req[$];
    rsp_exp_t exp_rsp0[$];
    rsp_exp_t exp_rsp1[$];
    plan_t    plan[$];

    int total = 0;
    int bad   = 0;
    int n_req_seen = 0;
    int n_rsp_seen = 0;
    logic [31:0] hold0 = '0;
    logic [31:0] hold1 = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [138:0] all_outs();
        return {request_enable, req_mode, req_addr, req_wdata, req_wstrb,
                m0_response_enable, m0_resp_data, m1_response_enable, m1_resp_data,
                busy, grant_id, bus_error};
    endfunction

    task automatic check_all_zero(input string name);
        logic [138:0] v;
        v = all_outs();
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL %s: got outputs 0x%0h required 0x0", name, v);
        end
    endtask

    // Each tick advances to 1 time unit after the next rising edge, ends any
    // request pulse and scrambles the live request fields so that a request
    // served from a pending slot cannot borrow them.
    task automatic tick();
        @(posedge clk);
        #1;
        m0_request_enable = 1'b0;
        m1_request_enable = 1'b0;
        m0_req_mode = 1'b1; m0_req_addr = 32'hCCCC_0000; m0_req_wdata = 32'hCCCC_1111; m0_req_wstrb = 4'h5;
        m1_req_mode = 1'b1; m1_req_addr = 32'hDDDD_0000; m1_req_wdata = 32'hDDDD_1111; m1_req_wstrb = 4'hA;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive0(input logic mode, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        m0_request_enable = 1'b1;
        m0_req_mode = mode; m0_req_addr = addr; m0_req_wdata = wdata; m0_req_wstrb = wstrb;
    endtask

    task automatic drive1(input logic mode, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        m1_request_enable = 1'b1;
        m1_req_mode = mode; m1_req_addr = addr; m1_req_wdata = wdata; m1_req_wstrb = wstrb;
    endtask

    task automatic expect_req(input int c, input logic gid, input logic mode, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
        req_exp_t e;
        e.cyc = c; e.gid = gid; e.mode = mode; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
        exp_req.push_back(e);
    endtask

    task automatic expect_rsp(input int port, input int c, input logic [31:0] data, input logic err);
        rsp_exp_t r;
        r.cyc = c; r.data = data; r.err = err;
        if (port == 0) exp_rsp0.push_back(r);
        else           exp_rsp1.push_back(r);
    endtask

    task automatic mem(input bit respond, input int delay, input logic [31:0] data);
        plan_t p;
        p.respond = respond; p.delay = delay; p.data = data;
        plan.push_back(p);
    endtask

    // Memory model: answers each request per the next plan entry.
    initial begin
        plan_t p;
        response_enable = 1'b0;
        resp_data       = '0;
        forever begin
            @(negedge clk);
            if (rstn && request_enable && plan.size() > 0) begin
                p = plan.pop_front();
                if (p.respond) begin
                    repeat (p.delay) @(posedge clk);
                    #1;
                    response_enable = 1'b1;
                    resp_data       = p.data;
                    @(posedge clk);
                    #1;
                    response_enable = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every DUT pulse against the scoreboard queues.
    initial begin
        req_exp_t e;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hold0 = '0;
                hold1 = '0;
            end else begin
                if (request_enable) begin
                    n_req_seen++;
                    if (exp_req.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got request addr 0x%08h required none (cycle %0d)", req_addr, cyc);
                    end else begin
                        e = exp_req.pop_front();
                        check32("req_addr", req_addr, e.addr);
                        check32("req_wdata", req_wdata, e.wdata);
                        check32("req_wstrb", {28'b0, req_wstrb}, {28'b0, e.wstrb});
                        check32("req_mode", {31'b0, req_mode}, {31'b0, e.mode});
                        check32("req_grant_id", {31'b0, grant_id}, {31'b0, e.gid});
                        if (e.cyc >= 0) check32("req_cycle", cyc, e.cyc);
                    end
                end
                if (m0_response_enable) begin
                    n_rsp_seen++;
                    if (exp_rsp0.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_m0_rsp: got data 0x%08h required none (cycle %0d)", m0_resp_data, cyc);
                    end else begin
                        r = exp_rsp0.pop_front();
                        hold0 = r.data;
                        check32("m0_rsp_err", {31'b0, bus_error}, {31'b0, r.err});
                        if (r.cyc >= 0) check32("m0_rsp_cycle", cyc, r.cyc);
                    end
                end
                if (m1_response_enable) begin
                    n_rsp_seen++;
                    if (exp_rsp1.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_m1_rsp: got data 0x%08h required none (cycle %0d)", m1_resp_data, cyc);
                    end else begin
                        r = exp_rsp1.pop_front();
                        hold1 = r.data;
                        check32("m1_rsp_err", {31'b0, bus_error}, {31'b0, r.err});
                        if (r.cyc >= 0) check32("m1_rsp_cycle", cyc, r.cyc);
                    end
                end
                if (bus_error && !m0_response_enable && !m1_response_enable) begin
                    n_rsp_seen++;
                    total++; bad++;
                    $display("FAIL lone_bus_error: got bus_error=1 required 0 without a response (cycle %0d)", cyc);
                end
                check32("m0_resp_data", m0_resp_data, hold0);
                check32("m1_resp_data", m1_resp_data, hold1);
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: run still active at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int t;
        int req_before;
        int rsp_before;

        rstn = 1'b0;
        m0_request_enable = 1'b0; m0_req_mode = 1'b0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_wstrb = '0;
        m1_request_enable = 1'b0; m1_req_mode = 1'b0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_wstrb = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        tick();
        rstn = 1'b1;
        idle(2);
        check_all_zero("post_reset_idle");

        // Simultaneous pair after reset: m0 first, m1 from its pending slot.
        t = cyc;
        drive0(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        drive1(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        expect_req(t + 1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        mem(1'b1, 1, 32'hA000_0001);
        expect_rsp(0, t + 3, 32'hA000_0001, 1'b0);
        expect_req(t + 5, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        mem(1'b1, 1, 32'hA000_0002);
        expect_rsp(1, t + 7, 32'hA000_0002, 1'b0);
        idle(12);

        // Repeated pair: last grant was m1, so m0 goes first again.
        t = cyc;
        drive0(1'b0, 32'h0000_0110, 32'h0, 4'h0);
        drive1(1'b0, 32'h0000_0210, 32'h0, 4'h0);
        expect_req(t + 1, 1'b0, 1'b0, 32'h0000_0110, 32'h0, 4'h0);
        mem(1'b1, 1, 32'hA000_0003);
        expect_rsp(0, t + 3, 32'hA000_0003, 1'b0);
        expect_req(t + 5, 1'b1, 1'b0, 32'h0000_0210, 32'h0, 4'h0);
        mem(1'b1, 1, 32'hA000_0004);
        expect_rsp(1, t + 7, 32'hA000_0004, 1'b0);
        idle(12);

        // Single m0 read, memory answers two cycles after the request.
        t = cyc;
        drive0(1'b0, 32'h8000_1000, 32'h0, 4'h0);
        expect_req(t + 1, 1'b0, 1'b0, 32'h8000_1000, 32'h0, 4'h0);
        mem(1'b1, 2, 32'hDEAD_BEEF);
        expect_rsp(0, t + 4, 32'hDEAD_BEEF, 1'b0);
        idle(10);

        // Pair with last grant m0: m1 wins the tie this time.
        t = cyc;
        drive0(1'b0, 32'h0000_0120, 32'h0, 4'h0);
        drive1(1'b0, 32'h0000_0220, 32'h0, 4'h0);
        expect_req(t + 1, 1'b1, 1'b0, 32'h0000_0220, 32'h0, 4'h0);
        mem(1'b1, 1, 32'hA000_0005);
        expect_rsp(1, t + 3, 32'hA000_0005, 1'b0);
        expect_req(t + 5, 1'b0, 1'b0, 32'h0000_0120, 32'h0, 4'h0);
        mem(1'b1, 1, 32'hA000_0006);
        expect_rsp(0, t + 7, 32'hA000_0006, 1'b0);
        idle(12);

        // m1 write arrives while m0 waits; issued after m0's RESPOND.
        t = cyc;
        drive0(1'b0, 32'h0000_0300, 32'h0, 4'h0);
        expect_req(t + 1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        mem(1'b1, 4, 32'hC0FF_EE00);
        expect_rsp(0, t + 6, 32'hC0FF_EE00, 1'b0);
        idle(2);
        drive1(1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF);
        expect_req(t + 8, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF);
        mem(1'b1, 1, 32'h5555_AAAA);
        expect_rsp(1, t + 10, 32'h5555_AAAA, 1'b0);
        idle(14);

        // Memory never answers in time: timeout after 8 WAIT_RESP cycles,
        // then a late response lands while idle and must be ignored.
        t = cyc;
        drive0(1'b0, 32'h0000_0500, 32'h0, 4'h0);
        expect_req(t + 1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
        mem(1'b1, 12, 32'hBAD0_BAD0);
        expect_rsp(0, t + 9, 32'h0, 1'b1);
        idle(14);
        check32("late_resp_ignored",
                {27'b0, m0_response_enable, m1_response_enable, bus_error, busy, request_enable}, 32'h0);
        idle(4);

        // Reset while m0 waits and m1 sits in its pending slot.
        t = cyc;
        drive0(1'b0, 32'h0000_0600, 32'h0, 4'h0);
        expect_req(t + 1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
        mem(1'b0, 0, 32'h0);
        idle(2);
        drive1(1'b0, 32'h0000_0700, 32'h0, 4'h0);
        tick();
        check32("busy_before_reset", {31'b0, busy}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        tick();
        tick();
        rstn = 1'b1;
        req_before = n_req_seen;
        rsp_before = n_rsp_seen;
        idle(12);
        check32("no_req_after_reset", n_req_seen, req_before);
        check32("no_rsp_after_reset", n_rsp_seen, rsp_before);
        check32("idle_after_reset", {31'b0, busy}, 32'h0);

        // New pair after reset: last grant is back to m1, so m0 goes first.
        t = cyc;
        drive0(1'b0, 32'h0000_0800, 32'h0, 4'h0);
        drive1(1'b1, 32'h0000_0900, 32'h0BAD_F00D, 4'h3);
        expect_req(t + 1, 1'b0, 1'b0, 32'h0000_0800, 32'h0, 4'h0);
        mem(1'b1, 1, 32'h1111_1111);
        expect_rsp(0, t + 3, 32'h1111_1111, 1'b0);
        expect_req(t + 5, 1'b1, 1'b1, 32'h0000_0900, 32'h0BAD_F00D, 4'h3);
        mem(1'b1, 1, 32'h2222_2222);
        expect_rsp(1, t + 7, 32'h2222_2222, 1'b0);
        idle(12);

        // Drain: everything expected must have been seen.
        for (int i = 0; i < 50 && (exp_req.size() + exp_rsp0.size() + exp_rsp1.size()) != 0; i++) begin
            tick();
        end
        check32("pending_req_expectations", exp_req.size(), 32'h0);
        check32("pending_m0_expectations", exp_rsp0.size(), 32'h0);
        check32("pending_m1_expectations", exp_rsp1.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
